// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: ICache request/response channel plus the fetch-to-decode queue head.
interface if_fetch_queue_if;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fd_valid;
    logic        fd_ready;
    logic [31:0] fd_pc;
    logic [31:0] fd_inst;
    logic        fd_ex;
    logic [4:0]  fd_excode;

    // Fetch stage side: issues cache requests, presents the queue head to ID
    modport master (
        output inst_valid, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output fd_valid, fd_pc, fd_inst, fd_ex, fd_excode,
        input  fd_ready
    );

    // Environment side: ICache and ID stage
    modport slave (
        input  inst_valid, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  fd_valid, fd_pc, fd_inst, fd_ex, fd_excode,
        output fd_ready
    );
endinterface

// File: rtl/if_fetch_queue.sv
// MIPS fetch stage: pre-IF PC generator, pipelined ICache requests with in-order
// responses, and an instruction queue feeding ID over a valid/ready handshake.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter logic [31:0] EXC_VEC    = 32'hbfc00380,
    parameter int unsigned IBUF_DEPTH = 4,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_exc_flush,
    input  logic             i_eret,
    input  logic [31:0]      i_cp0_epc,
    input  logic             i_br_redirect,
    input  logic [31:0]      i_br_target,
    if_fetch_queue_if.master bus
);

    localparam int unsigned QW = $clog2(IBUF_DEPTH);
    localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
    } fq_entry_t;

    logic [31:0] r_pc;
    logic        r_halt;
    logic [OW-1:0] r_outst_cnt;
    logic [OW-1:0] r_cancel_cnt;
    logic [31:0] r_tag [MAX_OUTST];
    logic [TW-1:0] r_tag_wptr;
    logic [TW-1:0] r_tag_rptr;
    fq_entry_t   r_q [IBUF_DEPTH];
    logic [QW-1:0] r_q_wptr;
    logic [QW-1:0] r_q_rptr;
    logic [CW-1:0] r_q_count;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_req;
    logic        w_acc;
    logic        w_rsp;
    logic        w_rsp_push;
    logic        w_mis_push;
    logic        w_push;
    logic        w_pop;
    fq_entry_t   w_push_entry;
    fq_entry_t   w_head;
    logic [TW-1:0] w_tag_wptr_nxt;
    logic [TW-1:0] w_tag_rptr_nxt;

    // Redirect selection, request credit, response/exception push and queue head decode
    always_comb begin
        w_redirect = i_eret | i_exc_flush | i_br_redirect;
        w_target   = i_br_target;
        if (i_exc_flush) w_target = EXC_VEC;
        if (i_eret)      w_target = i_cp0_epc;

        // Credit term reserves a queue slot for every in-flight response
        w_req = !reset && !w_redirect && !r_halt && (r_pc[1:0] == 2'b00)
                && (32'(r_outst_cnt) < MAX_OUTST)
                && ((32'(r_q_count) + 32'(r_outst_cnt)) < IBUF_DEPTH);
        w_acc = w_req && bus.inst_addr_ok;
        w_rsp = bus.inst_data_ok;

        w_rsp_push = w_rsp && (r_cancel_cnt == '0) && !w_redirect;
        w_mis_push = !reset && !r_halt && !w_redirect && (r_pc[1:0] != 2'b00)
                     && (r_outst_cnt == '0) && (r_cancel_cnt == '0)
                     && (r_q_count < CW'(IBUF_DEPTH));
        w_push = w_rsp_push || w_mis_push;
        w_pop  = (r_q_count != '0) && bus.fd_ready;

        w_push_entry = '{pc: r_tag[r_tag_rptr], inst: bus.inst_rdata, ex: 1'b0};
        if (w_mis_push) w_push_entry = '{pc: r_pc, inst: 32'h0, ex: 1'b1};

        w_head = r_q[r_q_rptr];

        w_tag_wptr_nxt = (32'(r_tag_wptr) == MAX_OUTST - 32'd1) ? '0 : r_tag_wptr + TW'(1);
        w_tag_rptr_nxt = (32'(r_tag_rptr) == MAX_OUTST - 32'd1) ? '0 : r_tag_rptr + TW'(1);
    end

    assign bus.inst_valid = w_req;
    assign bus.inst_addr  = r_pc;
    assign bus.fd_valid   = (r_q_count != '0);
    assign bus.fd_pc      = w_head.pc;
    assign bus.fd_inst    = w_head.inst;
    assign bus.fd_ex      = w_head.ex;
    assign bus.fd_excode  = w_head.ex ? 5'h04 : 5'h1f;

    // PC advance and misaligned-fetch halt
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc   <= RESET_PC;
            r_halt <= 1'b0;
        end else if (w_redirect) begin
            r_pc   <= w_target;
            r_halt <= 1'b0;
        end else begin
            if (w_acc)      r_pc   <= r_pc + 32'd4;
            if (w_mis_push) r_halt <= 1'b1;
        end
    end

    // Outstanding/cancel accounting and PC tag FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outst_cnt  <= '0;
            r_cancel_cnt <= '0;
            r_tag_wptr   <= '0;
            r_tag_rptr   <= '0;
        end else begin
            r_outst_cnt <= r_outst_cnt + OW'(w_acc) - OW'(w_rsp);
            if (w_redirect)
                r_cancel_cnt <= r_outst_cnt - OW'(w_rsp);
            else if (w_rsp && (r_cancel_cnt != '0))
                r_cancel_cnt <= r_cancel_cnt - OW'(1);
            if (w_acc) r_tag_wptr <= w_tag_wptr_nxt;
            if (w_rsp) r_tag_rptr <= w_tag_rptr_nxt;
        end
    end

    // PC tag storage for accepted requests
    always_ff @(posedge clk) begin
        if (w_acc) r_tag[r_tag_wptr] <= r_pc;
    end

    // Queue pointers and occupancy; redirect drops every queued entry
    always_ff @(posedge clk) begin
        if (reset || w_redirect) begin
            r_q_wptr  <= '0;
            r_q_rptr  <= '0;
            r_q_count <= '0;
        end else begin
            if (w_push) r_q_wptr <= r_q_wptr + QW'(1);
            if (w_pop)  r_q_rptr <= r_q_rptr + QW'(1);
            r_q_count <= r_q_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue entry storage
    always_ff @(posedge clk) begin
        if (w_push) r_q[r_q_wptr] <= w_push_entry;
    end

    // A response with nothing outstanding means the cache protocol was broken
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(bus.inst_data_ok && (r_outst_cnt == '0)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order ICache model and an ID-side stream checker.
module tb_if_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_VEC  = 32'hbfc00380;
    localparam logic [31:0] KEY      = 32'h1234_5678;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exc_flush, eret, br_redirect;
    logic [31:0] cp0_epc, br_target;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int accepts = 0;
    int cyc_n = 0;
    int lat = 1;
    bit mon_en = 1'b0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_addr = '0;
    req_t pend_q[$];
    int pops0, acc0, n;

    always #5 clk = ~clk;

    if_fetch_queue_if bus_if ();

    if_fetch_queue #(
        .RESET_PC  (RESET_PC),
        .EXC_VEC   (EXC_VEC),
        .IBUF_DEPTH(4),
        .MAX_OUTST (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_exc_flush  (exc_flush),
        .i_eret       (eret),
        .i_cp0_epc    (cp0_epc),
        .i_br_redirect(br_redirect),
        .i_br_target  (br_target),
        .bus          (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input string tag, input int max);
        int k = 0;
        #1;
        while (!bus_if.fd_valid && k < max) begin
            cyc();
            #1;
            k++;
        end
        chk(tag, 32'(bus_if.fd_valid), 32'd1);
    endtask

    // ICache model and ID-side stream checker, sampled mid-cycle on the falling edge
    initial begin
        bus_if.inst_data_ok = 1'b0;
        bus_if.inst_rdata   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_q.delete();
                bus_if.inst_data_ok = 1'b0;
                bus_if.inst_rdata   = '0;
            end else begin
                if (bus_if.fd_valid && bus_if.fd_ready) begin
                    pops++;
                    if (mon_en) begin
                        chk("stream_pc", bus_if.fd_pc, exp_pc);
                        chk("stream_inst", bus_if.fd_inst, exp_pc ^ KEY);
                        chk("stream_ex", 32'(bus_if.fd_ex), 32'd0);
                        exp_pc = exp_pc + 32'd4;
                    end
                end
                if (pend_q.size() > 0 && pend_q[0].rdy <= cyc_n) begin
                    bus_if.inst_data_ok = 1'b1;
                    bus_if.inst_rdata   = pend_q[0].addr ^ KEY;
                    void'(pend_q.pop_front());
                end else begin
                    bus_if.inst_data_ok = 1'b0;
                    bus_if.inst_rdata   = '0;
                end
                if (bus_if.inst_valid && bus_if.inst_addr_ok) begin
                    accepts++;
                    if (mon_en) begin
                        chk("req_addr", bus_if.inst_addr, exp_addr);
                        exp_addr = exp_addr + 32'd4;
                    end
                    pend_q.push_back('{addr: bus_if.inst_addr, rdy: cyc_n + lat});
                end
            end
            cyc_n++;
        end
    end

    // Hard stop if the run wedges
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exc_flush = 1'b0; eret = 1'b0; br_redirect = 1'b0;
        cp0_epc = '0; br_target = '0;
        bus_if.inst_addr_ok = 1'b0;
        bus_if.fd_ready     = 1'b0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_inst_valid", 32'(bus_if.inst_valid), 32'd0);
        chk("rst_fd_valid", 32'(bus_if.fd_valid), 32'd0);

        // T1: streaming from RESET_PC, 1-cycle cache, one instruction per cycle
        cyc();
        reset = 1'b0; bus_if.inst_addr_ok = 1'b1; bus_if.fd_ready = 1'b1;
        mon_en = 1'b1; exp_pc = RESET_PC; exp_addr = RESET_PC;
        pops0 = pops; acc0 = accepts;
        #1;
        chk("t1_first_addr", bus_if.inst_addr, RESET_PC);
        chk("t1_first_valid", 32'(bus_if.inst_valid), 32'd1);
        repeat (12) cyc();
        chk("t1_pops", 32'(pops - pops0), 32'd10);
        chk("t1_accepts", 32'(accepts - acc0), 32'd12);

        // T2: ID stalls, queue fills exactly and requests stop
        bus_if.fd_ready = 1'b0;
        repeat (10) cyc();
        #1;
        chk("t2_fd_valid", 32'(bus_if.fd_valid), 32'd1);
        chk("t2_inst_valid", 32'(bus_if.inst_valid), 32'd0);
        chk("t2_queued", 32'(accepts - pops), 32'd4);
        chk("t2_head_pc", bus_if.fd_pc, exp_pc);
        bus_if.fd_ready = 1'b1;
        repeat (8) cyc();

        // T3: branch redirect with two requests outstanding
        lat = 3;
        n = 0;
        while (pend_q.size() != 2 && n < 20) begin cyc(); n++; end
        chk("t3_outst", 32'(pend_q.size()), 32'd2);
        #1;
        chk("t3_outst_full_iv", 32'(bus_if.inst_valid), 32'd0);
        br_redirect = 1'b1; br_target = 32'h80001000;
        #1;
        chk("t3_redir_iv", 32'(bus_if.inst_valid), 32'd0);
        cyc();
        br_redirect = 1'b0; lat = 1;
        exp_pc = 32'h80001000; exp_addr = 32'h80001000;
        #1;
        chk("t3_q_empty", 32'(bus_if.fd_valid), 32'd0);
        chk("t3_addr", bus_if.inst_addr, 32'h80001000);
        wait_fd("t3_wait_fd", 20);
        chk("t3_fd_pc", bus_if.fd_pc, 32'h80001000);
        chk("t3_fd_inst", bus_if.fd_inst, 32'h80001000 ^ KEY);
        repeat (4) cyc();

        // T4: eret beats exc_flush
        eret = 1'b1; exc_flush = 1'b1; cp0_epc = 32'h80000100;
        #1;
        chk("t4_redir_iv", 32'(bus_if.inst_valid), 32'd0);
        cyc();
        eret = 1'b0; exc_flush = 1'b0;
        exp_pc = 32'h80000100; exp_addr = 32'h80000100;
        #1;
        chk("t4_addr", bus_if.inst_addr, 32'h80000100);
        wait_fd("t4_wait_fd", 10);
        chk("t4_fd_pc", bus_if.fd_pc, 32'h80000100);
        repeat (4) cyc();

        // T5: misaligned branch target raises AdEL once and halts fetch
        mon_en = 1'b0; bus_if.fd_ready = 1'b0;
        br_redirect = 1'b1; br_target = 32'h80000002;
        cyc();
        br_redirect = 1'b0; acc0 = accepts;
        wait_fd("t5_wait_fd", 10);
        chk("t5_fd_pc", bus_if.fd_pc, 32'h80000002);
        chk("t5_fd_ex", 32'(bus_if.fd_ex), 32'd1);
        chk("t5_excode", 32'(bus_if.fd_excode), 32'h04);
        chk("t5_fd_inst", bus_if.fd_inst, 32'h0);
        repeat (3) cyc();
        #1;
        chk("t5_no_req", 32'(accepts - acc0), 32'd0);
        chk("t5_halt_iv", 32'(bus_if.inst_valid), 32'd0);
        chk("t5_held", 32'(bus_if.fd_valid), 32'd1);
        bus_if.fd_ready = 1'b1;
        cyc();
        bus_if.fd_ready = 1'b0;
        repeat (3) cyc();
        #1;
        chk("t5_single_entry", 32'(bus_if.fd_valid), 32'd0);
        exc_flush = 1'b1;
        cyc();
        exc_flush = 1'b0; mon_en = 1'b1; bus_if.fd_ready = 1'b1;
        exp_pc = EXC_VEC; exp_addr = EXC_VEC;
        #1;
        chk("t5_exc_addr", bus_if.inst_addr, EXC_VEC);
        chk("t5_exc_iv", 32'(bus_if.inst_valid), 32'd1);
        wait_fd("t5_exc_wait_fd", 10);
        chk("t5_exc_fd_pc", bus_if.fd_pc, EXC_VEC);
        repeat (4) cyc();

        // T6: reset with requests in flight
        lat = 3;
        n = 0;
        while (pend_q.size() == 0 && n < 10) begin cyc(); n++; end
        chk("t6_inflight", 32'(pend_q.size() != 0), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_iv", 32'(bus_if.inst_valid), 32'd0);
        cyc();
        reset = 1'b0; lat = 1;
        exp_pc = RESET_PC; exp_addr = RESET_PC;
        pops0 = pops; acc0 = accepts;
        #1;
        chk("t6_fd_valid", 32'(bus_if.fd_valid), 32'd0);
        chk("t6_addr", bus_if.inst_addr, RESET_PC);
        chk("t6_iv", 32'(bus_if.inst_valid), 32'd1);
        repeat (10) cyc();
        chk("t6_pops", 32'(pops - pops0), 32'd8);
        chk("t6_accepts", 32'(accepts - acc0), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
